// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - read/write-back/issue bundle between an issue stage and the register scoreboard
interface regfile_scoreboard_if #(
    parameter int WIDTH = 32
);
  logic [4:0]       Rna;
  logic [4:0]       Rnb;
  logic [WIDTH-1:0] Qa;
  logic [WIDTH-1:0] Qb;
  logic             Use_a;
  logic             Use_b;
  logic             We;
  logic [4:0]       Wn;
  logic [WIDTH-1:0] D;
  logic             Issue;
  logic [4:0]       Issue_rd;
  logic             Busy_a;
  logic             Busy_b;
  logic             Stall;
  logic [5:0]       Pending_cnt;
  logic             Idle;

  modport master (
    output Rna, Rnb, Use_a, Use_b, We, Wn, D, Issue, Issue_rd,
    input  Qa, Qb, Busy_a, Busy_b, Stall, Pending_cnt, Idle
  );

  modport slave (
    input  Rna, Rnb, Use_a, Use_b, We, Wn, D, Issue, Issue_rd,
    output Qa, Qb, Busy_a, Busy_b, Stall, Pending_cnt, Idle
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - two-read/one-write register file with write bypass and per-register pending scoreboard
module regfile_scoreboard #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
) (
    input  logic                  Clk,
    input  logic                  Clr,
    regfile_scoreboard_if.slave   bus
);

  logic [WIDTH-1:0] r_regs [NREG];
  logic [NREG-1:0]  r_pending;
  logic [5:0]       r_pending_cnt;

  logic w_wr_en;
  logic w_byp_a;
  logic w_byp_b;
  logic w_busy_a;
  logic w_busy_b;
  logic w_rd_pend;
  logic w_stall;
  logic w_set;
  logic w_inc;
  logic w_dec;

  assign w_wr_en = bus.We && (bus.Wn != 5'd0);
  assign w_byp_a = w_wr_en && (bus.Wn == bus.Rna);
  assign w_byp_b = w_wr_en && (bus.Wn == bus.Rnb);

  always_comb begin
    bus.Qa = '0;
    if (w_byp_a)
      bus.Qa = bus.D;
    else if (bus.Rna != 5'd0)
      bus.Qa = r_regs[bus.Rna];
  end

  always_comb begin
    bus.Qb = '0;
    if (w_byp_b)
      bus.Qb = bus.D;
    else if (bus.Rnb != 5'd0)
      bus.Qb = r_regs[bus.Rnb];
  end

  // A write-back landing this cycle resolves the hazard it would otherwise report.
  assign w_busy_a  = (bus.Rna != 5'd0) && r_pending[bus.Rna]
                     && !(bus.We && (bus.Wn == bus.Rna));
  assign w_busy_b  = (bus.Rnb != 5'd0) && r_pending[bus.Rnb]
                     && !(bus.We && (bus.Wn == bus.Rnb));
  assign w_rd_pend = r_pending[bus.Issue_rd]
                     && !(bus.We && (bus.Wn == bus.Issue_rd));

  assign w_stall = bus.Issue && ((w_busy_a && bus.Use_a) ||
                                 (w_busy_b && bus.Use_b) ||
                                 w_rd_pend);
  assign w_set   = bus.Issue && !w_stall && (bus.Issue_rd != 5'd0);

  // Net counter change; a same-index set and clear leaves the bit at 1 and the count unchanged.
  assign w_inc = w_set && !r_pending[bus.Issue_rd];
  assign w_dec = w_wr_en && r_pending[bus.Wn]
                 && !(w_set && (bus.Issue_rd == bus.Wn));

  always_ff @(posedge Clk) begin
    if (Clr) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
      r_pending     <= '0;
      r_pending_cnt <= 6'd0;
    end else begin
      if (w_wr_en)
        r_regs[bus.Wn] <= bus.D;
      if (w_wr_en)
        r_pending[bus.Wn] <= 1'b0;
      if (w_set)
        r_pending[bus.Issue_rd] <= 1'b1;
      r_pending_cnt <= r_pending_cnt + {5'd0, w_inc} - {5'd0, w_dec};
    end
  end

  assign bus.Busy_a      = w_busy_a;
  assign bus.Busy_b      = w_busy_b;
  assign bus.Stall       = w_stall;
  assign bus.Pending_cnt = r_pending_cnt;
  assign bus.Idle        = (r_pending_cnt == 6'd0);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard with directed and random stimulus
module tb_regfile_scoreboard;

  typedef struct {
    int          id;
    logic [31:0] qa;
    logic [31:0] qb;
    logic        busy_a;
    logic        busy_b;
    logic        stall;
    logic [5:0]  cnt;
    logic        idle;
  } exp_t;

  logic Clk = 1'b0;
  logic Clr;
  always #5 Clk = ~Clk;

  regfile_scoreboard_if #(.WIDTH(32)) bus ();

  regfile_scoreboard #(.WIDTH(32), .NREG(32)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  logic [31:0] m_reg  [32];
  bit          m_pend [32];
  exp_t        exp_q  [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          last_stall = 0;

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step=%0d actual=%h required=%h", nm, id, act, req);
    end
  endtask

  // One cycle: apply inputs, predict outputs from the model, then advance the model across the edge.
  task automatic drive(input bit chk, input int id, input logic clr, input logic we,
                       input logic [4:0] wn, input logic [31:0] d,
                       input logic [4:0] rna, input logic [4:0] rnb,
                       input logic ua, input logic ub, input logic iss, input logic [4:0] ird);
    exp_t e;
    bit   ba, bb, rp;
    int   cnt;
    @(posedge Clk);
    #1;
    Clr = clr; bus.We = we; bus.Wn = wn; bus.D = d;
    bus.Rna = rna; bus.Rnb = rnb; bus.Use_a = ua; bus.Use_b = ub;
    bus.Issue = iss; bus.Issue_rd = ird;

    ba = (rna != 0) && m_pend[rna] && !(we && wn == rna);
    bb = (rnb != 0) && m_pend[rnb] && !(we && wn == rnb);
    rp = m_pend[ird] && !(we && wn == ird);
    cnt = 0;
    for (int i = 0; i < 32; i++) cnt += m_pend[i] ? 1 : 0;
    e.id     = id;
    e.qa     = (we && wn != 0 && wn == rna) ? d : ((rna == 0) ? 32'd0 : m_reg[rna]);
    e.qb     = (we && wn != 0 && wn == rnb) ? d : ((rnb == 0) ? 32'd0 : m_reg[rnb]);
    e.busy_a = ba;
    e.busy_b = bb;
    e.stall  = iss && ((ba && ua) || (bb && ub) || rp);
    e.cnt    = 6'(cnt);
    e.idle   = (cnt == 0);
    if (chk) exp_q.push_back(e);
    last_stall = e.stall;

    if (clr) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 32'd0;
        m_pend[i] = 0;
      end
    end else begin
      if (we && wn != 0) begin
        m_reg[wn]  = d;
        m_pend[wn] = 0;
      end
      if (iss && !e.stall && ird != 0) m_pend[ird] = 1;
    end
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("Qa",          e.id, bus.Qa,          e.qa);
      check("Qb",          e.id, bus.Qb,          e.qb);
      check("Busy_a",      e.id, bus.Busy_a,      e.busy_a);
      check("Busy_b",      e.id, bus.Busy_b,      e.busy_b);
      check("Stall",       e.id, bus.Stall,       e.stall);
      check("Pending_cnt", e.id, bus.Pending_cnt, e.cnt);
      check("Idle",        e.id, bus.Idle,        e.idle);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before stimulus completed");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic        we, ua, ub, iss, clr;
    logic [4:0]  wn, rna, rnb, ird;
    logic [31:0] d;
    int          id;

    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'd0;
      m_pend[i] = 0;
    end
    Clr = 1'b1; bus.We = 0; bus.Wn = 0; bus.D = 0; bus.Rna = 0; bus.Rnb = 0;
    bus.Use_a = 0; bus.Use_b = 0; bus.Issue = 0; bus.Issue_rd = 0;

    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Post-reset state and same-cycle bypass into reg5.
    drive(1, 1, 0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 0, 0, 0, 0);
    drive(1, 2, 0, 0, 0, 0, 5'd5, 5'd5, 0, 0, 0, 0);
    // Register 0 is never written.
    drive(1, 3, 0, 1, 5'd0, 32'h1234, 5'd0, 5'd0, 0, 0, 0, 0);
    drive(1, 4, 0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0);
    // RAW hazard on r7, then resolved by a same-cycle write-back.
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
    drive(1, 6, 0, 0, 0, 0, 5'd7, 0, 1, 0, 1, 5'd8);
    drive(1, 7, 0, 1, 5'd7, 32'h77, 5'd7, 0, 1, 0, 1, 5'd8);
    drive(1, 8, 0, 1, 5'd8, 32'h88, 5'd7, 5'd8, 0, 0, 0, 0);
    // Same-index set and clear: set wins, count unchanged.
    drive(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
    drive(1, 10, 0, 1, 5'd9, 32'h99, 5'd9, 0, 0, 0, 1, 5'd9);
    drive(1, 11, 0, 0, 0, 0, 5'd9, 5'd9, 1, 1, 1, 5'd10);
    drive(1, 12, 0, 1, 5'd9, 32'h9A, 0, 0, 0, 0, 0, 0);
    // Fill every pending bit, then reset with a write that must be discarded.
    for (int r = 1; r < 32; r++)
      drive(1, 100 + r, 0, 0, 0, 0, 5'(r), 0, 0, 0, 1, 5'(r));
    drive(1, 140, 0, 0, 0, 0, 5'd31, 5'd1, 0, 0, 0, 0);
    drive(1, 141, 1, 1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd5, 0, 0, 1, 5'd4);
    drive(1, 142, 0, 0, 0, 0, 5'd3, 5'd5, 1, 1, 1, 5'd3);
    // Write to a discarded pending register must not underflow the count.
    drive(1, 143, 0, 1, 5'd3, 32'h33, 5'd3, 0, 0, 0, 0, 0);
    drive(1, 144, 0, 1, 5'd12, 32'h12, 5'd3, 5'd12, 0, 0, 0, 0);

    iss = 0; ird = 0; ua = 0; ub = 0; rna = 0; rnb = 0;
    for (int k = 0; k < 1500; k++) begin
      id  = 1000 + k;
      clr = ($urandom_range(0, 99) == 0);
      we  = ($urandom_range(0, 9) < 4);
      wn  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      d   = $urandom;
      // A stalled requester keeps presenting the same instruction.
      if (!(iss && last_stall)) begin
        iss = ($urandom_range(0, 1) == 1);
        ird = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        rna = 5'($urandom_range(0, 7));
        rnb = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        ua  = ($urandom_range(0, 2) != 0);
        ub  = ($urandom_range(0, 2) != 0);
      end
      drive(1, id, clr, we, wn, d, rna, rnb, ua, ub, iss, ird);
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge Clk);
    check("queue_drained", 9999, exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
